// File: rtl/fpu_op_dispatch.sv
// FP request dispatcher: issues one op to add/sub/mul/div units and tracks issue order
// in an opcode FIFO whose head selects the result mux.
module fpu_op_dispatch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 2,
    parameter int unsigned ORD_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [OP_WIDTH-1:0]           req_opcode,
    input  logic [DATA_WIDTH-1:0]         req_a,
    input  logic [DATA_WIDTH-1:0]         req_b,
    output logic [3:0]                    unit_valid,
    input  logic [3:0]                    unit_ready,
    output logic [DATA_WIDTH-1:0]         unit_a,
    output logic [DATA_WIDTH-1:0]         unit_b,
    output logic                          ord_valid,
    output logic [OP_WIDTH-1:0]           ord_opcode,
    input  logic                          ord_pop,
    output logic [$clog2(ORD_DEPTH):0]    ord_count
);

    localparam int unsigned PTR_W = $clog2(ORD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [OP_WIDTH-1:0] op_q;
    logic [OP_WIDTH-1:0] op_d;
    logic                issue_done;
    logic                ord_full;
    logic                accept;
    logic                pop;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [OP_WIDTH-1:0] ord_mem [ORD_DEPTH];

    assign ord_full   = (ord_count == CNT_W'(ORD_DEPTH));
    assign ord_valid  = (ord_count != '0);
    assign ord_opcode = ord_mem[rd_ptr];
    assign pop        = ord_pop && ord_valid;

    // Next-state, handshake and accept logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        issue_done = (state_q == ISSUE) && unit_ready[op_q];
        req_ready  = !rst && !ord_full && ((state_q == IDLE) || issue_done);
        accept     = req_valid && req_ready;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                if (issue_done && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) op_d = req_opcode;
    end

    // FSM, operand and issue-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            unit_valid <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            unit_valid <= (state_d == ISSUE) ? (4'b0001 << op_d) : 4'b0000;
            if (accept) begin
                unit_a <= req_a;
                unit_b <= req_b;
            end
        end
    end

    // Order FIFO: push on accept, pop on consumed result; power-of-2 pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ord_count <= '0;
            for (int i = 0; i < int'(ORD_DEPTH); i++) ord_mem[i] <= '0;
        end else begin
            if (accept) begin
                ord_mem[wr_ptr] <= req_opcode;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   ord_count <= ord_count + CNT_W'(1);
                2'b01:   ord_count <= ord_count - CNT_W'(1);
                default: ord_count <= ord_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Directed self-checking bench for fpu_op_dispatch: reset, single issue, backpressure,
// back-to-back issue, FIFO full/pop behaviour and reset while an op is held.
module tb_fpu_op_dispatch;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned OP_WIDTH   = 2;
    localparam int unsigned ORD_DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_valid;
    logic                   req_ready;
    logic [OP_WIDTH-1:0]    req_opcode;
    logic [DATA_WIDTH-1:0]  req_a;
    logic [DATA_WIDTH-1:0]  req_b;
    logic [3:0]             unit_valid;
    logic [3:0]             unit_ready;
    logic [DATA_WIDTH-1:0]  unit_a;
    logic [DATA_WIDTH-1:0]  unit_b;
    logic                   ord_valid;
    logic [OP_WIDTH-1:0]    ord_opcode;
    logic                   ord_pop;
    logic [2:0]             ord_count;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_op_dispatch #(
        .DATA_WIDTH(DATA_WIDTH),
        .OP_WIDTH  (OP_WIDTH),
        .ORD_DEPTH (ORD_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_a     (req_a),
        .req_b     (req_b),
        .unit_valid(unit_valid),
        .unit_ready(unit_ready),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .ord_valid (ord_valid),
        .ord_opcode(ord_opcode),
        .ord_pop   (ord_pop),
        .ord_count (ord_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic v, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        req_valid  = v;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
    endtask

    initial begin
        rst        = 1'b1;
        ord_pop    = 1'b0;
        unit_ready = 4'h0;
        drive_req(1'b0, 2'd0, 32'h0, 32'h0);

        // Reset held two cycles.
        step();
        step();
        check("rst_unit_valid", 64'(unit_valid), 64'h0);
        check("rst_ord_valid",  64'(ord_valid),  64'h0);
        check("rst_ord_count",  64'(ord_count),  64'h0);
        check("rst_ord_opcode", 64'(ord_opcode), 64'h0);
        check("rst_req_ready",  64'(req_ready),  64'h0);
        check("rst_unit_a",     64'(unit_a),     64'h0);
        rst = 1'b0;
        #1 check("post_rst_req_ready", 64'(req_ready), 64'h1);

        // Single mul.
        unit_ready = 4'hF;
        drive_req(1'b1, 2'b10, 32'h4000_0000, 32'h3F80_0000);
        step();
        drive_req(1'b0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("mul_unit_valid", 64'(unit_valid), 64'h4);
        check("mul_unit_a",     64'(unit_a),     64'h4000_0000);
        check("mul_unit_b",     64'(unit_b),     64'h3F80_0000);
        check("mul_ord_opcode", 64'(ord_opcode), 64'h2);
        check("mul_ord_count",  64'(ord_count),  64'h1);
        step();
        check("mul_idle_valid", 64'(unit_valid), 64'h0);
        ord_pop = 1'b1;
        step();
        ord_pop = 1'b0;
        check("mul_pop_count", 64'(ord_count), 64'h0);

        // Div with backpressure from the div unit only.
        unit_ready = 4'h7;
        drive_req(1'b1, 2'b11, 32'h1111_2222, 32'h3333_4444);
        step();
        drive_req(1'b1, 2'b00, 32'h5555_5555, 32'h6666_6666);
        for (int i = 0; i < 5; i++) begin
            check("bp_unit_valid", 64'(unit_valid), 64'h8);
            check("bp_unit_a",     64'(unit_a),     64'h1111_2222);
            check("bp_unit_b",     64'(unit_b),     64'h3333_4444);
            check("bp_req_ready",  64'(req_ready),  64'h0);
            step();
        end
        req_valid  = 1'b0;
        unit_ready = 4'hF;
        #1 check("bp_release_ready", 64'(req_ready), 64'h1);
        step();
        check("bp_done_valid", 64'(unit_valid), 64'h0);
        check("bp_done_count", 64'(ord_count),  64'h1);
        ord_pop = 1'b1;
        step();
        ord_pop = 1'b0;
        check("bp_pop_count", 64'(ord_count), 64'h0);

        // Back-to-back add, sub, mul, div.
        drive_req(1'b1, 2'b00, 32'hA0, 32'hB0);
        step();
        check("b2b_add_valid", 64'(unit_valid), 64'h1);
        drive_req(1'b1, 2'b01, 32'hA1, 32'hB1);
        step();
        check("b2b_sub_valid", 64'(unit_valid), 64'h2);
        check("b2b_sub_a",     64'(unit_a),     64'hA1);
        drive_req(1'b1, 2'b10, 32'hA2, 32'hB2);
        step();
        check("b2b_mul_valid", 64'(unit_valid), 64'h4);
        drive_req(1'b1, 2'b11, 32'hA3, 32'hB3);
        step();
        check("b2b_div_valid", 64'(unit_valid), 64'h8);
        check("b2b_div_b",     64'(unit_b),     64'hB3);
        check("b2b_count",     64'(ord_count),  64'h4);
        check("b2b_full_ready", 64'(req_ready), 64'h0);
        req_valid = 1'b0;
        step();
        check("full_idle_valid", 64'(unit_valid), 64'h0);
        check("full_head",       64'(ord_opcode), 64'h0);

        // Full: pop while requesting; no push this cycle.
        drive_req(1'b1, 2'b01, 32'hC0, 32'hD0);
        ord_pop = 1'b1;
        #1 check("full_pop_ready", 64'(req_ready), 64'h0);
        step();
        check("full_pop_count", 64'(ord_count),  64'h3);
        check("full_pop_head",  64'(ord_opcode), 64'h1);
        check("full_pop_valid", 64'(unit_valid), 64'h0);
        check("after_pop_ready", 64'(req_ready), 64'h1);

        // Push and pop in the same cycle.
        drive_req(1'b1, 2'b11, 32'hC1, 32'hD1);
        step();
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        check("pp_count",      64'(ord_count),  64'h3);
        check("pp_head",       64'(ord_opcode), 64'h2);
        check("pp_unit_valid", 64'(unit_valid), 64'h8);
        check("pp_unit_a",     64'(unit_a),     64'hC1);
        step();
        check("pp_head2",  64'(ord_opcode), 64'h3);
        check("pp_count2", 64'(ord_count),  64'h2);
        step();
        check("pp_head3",  64'(ord_opcode), 64'h3);
        check("pp_count3", 64'(ord_count),  64'h1);
        step();
        check("drain_count", 64'(ord_count), 64'h0);
        check("drain_valid", 64'(ord_valid), 64'h0);

        // Pop on empty FIFO has no effect.
        step();
        check("empty_pop_count", 64'(ord_count), 64'h0);
        check("empty_pop_valid", 64'(ord_valid), 64'h0);
        ord_pop = 1'b0;

        // Reset while a sub is held behind backpressure.
        unit_ready = 4'hD;
        drive_req(1'b1, 2'b00, 32'hE0, 32'hF0);
        step();
        drive_req(1'b1, 2'b01, 32'hE1, 32'hF1);
        step();
        req_valid = 1'b0;
        check("mid_unit_valid", 64'(unit_valid), 64'h2);
        check("mid_count",      64'(ord_count),  64'h2);
        rst = 1'b1;
        step();
        check("mid_rst_valid",  64'(unit_valid), 64'h0);
        check("mid_rst_count",  64'(ord_count),  64'h0);
        check("mid_rst_ovalid", 64'(ord_valid),  64'h0);
        check("mid_rst_ready",  64'(req_ready),  64'h0);
        rst = 1'b0;
        step();
        check("mid_post_valid", 64'(unit_valid), 64'h0);
        check("mid_post_ready", 64'(req_ready),  64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
